// File: rtl/ham84_enc_tx.sv
// (8,4) extended-Hamming encoder with error injection and a codeword FIFO.
// Upstream words are encoded, optionally corrupted, queued, then streamed out.
module ham84_enc_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_data,
    input  logic                            inj_en,
    input  logic [7:0]                      inj_mask,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [7:0]                      out_codeword,
    output logic                            out_injected,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [COUNT_W-1:0]              word_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

    logic [7:0]       cw_mem  [FIFO_DEPTH];
    logic             inj_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [7:0]       enc_cw;
    logic [7:0]       store_cw;
    logic             store_inj;
    logic             push;
    logic             pop;

    always_comb begin
        enc_cw      = 8'h00;
        enc_cw[7:4] = in_data;
        enc_cw[0]   = in_data[0] ^ in_data[1] ^ in_data[3];
        enc_cw[1]   = in_data[0] ^ in_data[2] ^ in_data[3];
        enc_cw[2]   = in_data[1] ^ in_data[2] ^ in_data[3];
        enc_cw[3]   = in_data[0] ^ in_data[1] ^ in_data[2];
        store_cw    = enc_cw ^ (inj_en ? inj_mask : 8'h00);
        store_inj   = inj_en && (inj_mask != 8'h00);
    end

    // Ready comes from the level register only, so a same-cycle pop never frees a full slot.
    assign in_ready   = (level != FULL);
    assign out_valid  = (level != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign fifo_level = level;

    assign out_codeword = out_valid ? cw_mem[rd_ptr] : 8'h00;
    assign out_injected = out_valid ? inj_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            cw_mem[wr_ptr]  <= store_cw;
            inj_mem[wr_ptr] <= store_inj;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            word_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop && (word_count != '1))
                word_count <= word_count + 1'b1;
        end
    end
endmodule
